// File: rtl/wb_redirect_ctrl_pkg.sv
// Shared types for the writeback redirect controller: event causes, FSM states, constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_EXC  = 3'd1,
        RC_ERET = 3'd2,
        RC_JMP  = 3'd3,
        RC_MTC0 = 3'd4
    } redirect_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_INT_WAIT = 2'd3
    } wbctl_state_e;

    // Default exception entry point (BEV=1 general exception vector).
    localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;

    // MTC0 resumes after the dual-issue pair, i.e. lane-2 PC + 8.
    localparam int MTC0_RESUME_OFS = 8;

    // Causes that change CP0 state and therefore need issue held afterwards.
    function automatic logic is_drain_cause(input redirect_cause_e c);
        return (c == RC_ERET) || (c == RC_MTC0);
    endfunction

endpackage

// File: rtl/wb_redirect_ctrl_if.sv
// Bundle between the writeback stage (master) and the redirect controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; stall_issue is the only throttle and flows slave -> master.
// Ports: writeback event summary, CP0 interrupt state and per-stage valids in;
//        flush vector, issue stall, PC redirect strobe/target and interrupt tag out.
interface wb_redirect_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int PC_W       = 32
);
    logic                  exception_valid;
    logic                  eret_exist;
    logic                  mtc0_exist;
    logic                  jmp_valid;
    logic [PC_W-1:0]       jmp_pc;
    logic [PC_W-1:0]       exc_vector;
    logic [PC_W-1:0]       epc;
    logic [PC_W-1:0]       wb_pc;
    logic                  int_pending;
    logic [NUM_STAGES-1:0] stage_valid;

    logic [NUM_STAGES-1:0] flush;
    logic                  stall_issue;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;
    logic                  int_take;

    modport master (
        output exception_valid, eret_exist, mtc0_exist, jmp_valid,
               jmp_pc, exc_vector, epc, wb_pc, int_pending, stage_valid,
        input  flush, stall_issue, redirect_valid, redirect_pc, int_take
    );

    modport slave (
        input  exception_valid, eret_exist, mtc0_exist, jmp_valid,
               jmp_pc, exc_vector, epc, wb_pc, int_pending, stage_valid,
        output flush, stall_issue, redirect_valid, redirect_pc, int_take
    );
endinterface

// File: rtl/wb_redirect_ctrl_event_prio.sv
// Priority encoder for writeback redirect events: exception > ERET > jump > MTC0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: four event flags plus their candidate PCs in; winning cause and target out.
module wb_event_prio
    import wb_redirect_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            exception_valid,
    input  logic            eret_exist,
    input  logic            jmp_valid,
    input  logic            mtc0_exist,
    input  logic [PC_W-1:0] exc_vector,
    input  logic [PC_W-1:0] epc,
    input  logic [PC_W-1:0] jmp_pc,
    input  logic [PC_W-1:0] wb_pc,
    output redirect_cause_e cause,
    output logic [PC_W-1:0] target
);

    always_comb begin
        cause  = RC_NONE;
        target = '0;
        if (exception_valid) begin
            cause  = RC_EXC;
            target = exc_vector;
        end else if (eret_exist) begin
            cause  = RC_ERET;
            target = epc;
        end else if (jmp_valid) begin
            cause  = RC_JMP;
            target = jmp_pc;
        end else if (mtc0_exist) begin
            cause  = RC_MTC0;
            target = wb_pc + PC_W'(MTC0_RESUME_OFS);
        end
    end

endmodule

// File: rtl/wb_redirect_ctrl.sv
// Writeback redirect/flush sequencer: flushes younger stages, redirects fetch, drains after CP0 writes, injects interrupts.
// Latency: flush combinational in the event cycle, redirect strobe registered one cycle later.
// Backpressure: stall_issue holds fetch/decode during the CP0 drain window and while an interrupt tag is in flight.
// Ports: clk, resetn (synchronous, active-low), bus (slave side of wb_redirect_ctrl_if).
module wb_redirect_ctrl
    import wb_redirect_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    wb_redirect_ctrl_if.slave bus
);

    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    wbctl_state_e    state;
    redirect_cause_e cause_q;
    logic [CNT_W-1:0] drain_cnt;
    logic             redirect_valid_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic             stall_q;

    redirect_cause_e evt_cause;
    logic [PC_W-1:0] evt_target;
    logic            evt_any;
    logic            accept;
    logic            int_fire;
    logic            unused_stage_bits;

    wb_event_prio #(.PC_W(PC_W)) u_prio (
        .exception_valid (bus.exception_valid),
        .eret_exist      (bus.eret_exist),
        .jmp_valid       (bus.jmp_valid),
        .mtc0_exist      (bus.mtc0_exist),
        .exc_vector      (bus.exc_vector),
        .epc             (bus.epc),
        .jmp_pc          (bus.jmp_pc),
        .wb_pc           (bus.wb_pc),
        .cause           (evt_cause),
        .target          (evt_target)
    );

    // Only the memory-stage valid matters for interrupt injection.
    assign unused_stage_bits = ^bus.stage_valid;

    assign evt_any = (evt_cause != RC_NONE);

    // Events are taken in IDLE and INT_WAIT (an older instruction beats the
    // pending interrupt tag). During DRAIN only an exception may preempt;
    // anything seen in REDIRECT comes from squashed instructions.
    always_comb begin
        accept = 1'b0;
        case (state)
            ST_IDLE, ST_INT_WAIT: accept = evt_any;
            ST_DRAIN:             accept = bus.exception_valid;
            default:              accept = 1'b0;
        endcase
        accept = accept & resetn;
    end

    assign int_fire = resetn && (state == ST_IDLE) && !evt_any &&
                      bus.int_pending && bus.stage_valid[NUM_STAGES-1];

    // Combinational outputs are masked while reset is held; registered ones
    // clear on the reset edge.
    assign bus.flush          = (resetn && ((state == ST_REDIRECT) || accept)) ?
                                {NUM_STAGES{1'b1}} : {NUM_STAGES{1'b0}};
    assign bus.int_take       = int_fire;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.stall_issue    = stall_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            cause_q          <= RC_NONE;
            drain_cnt        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_q          <= 1'b0;
        end else begin
            // The redirect strobe and its PC live for exactly one cycle.
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;

            if (accept) begin
                state            <= ST_REDIRECT;
                cause_q          <= evt_cause;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= evt_target;
                stall_q          <= 1'b0;
                drain_cnt        <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (int_fire) begin
                            state   <= ST_INT_WAIT;
                            stall_q <= 1'b1;
                        end
                    end
                    ST_REDIRECT: begin
                        if (is_drain_cause(cause_q) && (DRAIN_CYCLES > 0)) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= CNT_W'(DRAIN_CYCLES);
                            stall_q   <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            stall_q <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt <= CNT_W'(1)) begin
                            state     <= ST_IDLE;
                            drain_cnt <= '0;
                            stall_q   <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                    ST_INT_WAIT: begin
                        // Held until the tagged instruction (or an older
                        // event) reaches writeback.
                        stall_q <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        stall_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_redirect_ctrl.sv
// Bench for wb_redirect_ctrl: timeline reference model, directed scenarios, random soak.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_redirect_ctrl;
    import wb_redirect_ctrl_pkg::*;

    localparam int NS = 4;
    localparam int D  = 2;

    logic clk;
    logic resetn;

    wb_redirect_ctrl_if #(.NUM_STAGES(NS), .PC_W(32)) bus ();

    wb_redirect_ctrl #(.NUM_STAGES(NS), .DRAIN_CYCLES(D), .PC_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a timeline of absolute cycle numbers rather than states.
    int          cyc        = 0;
    int          redir_cyc  = -1;   // cycle in which the redirect strobe is due
    logic [31:0] redir_pc_m = '0;
    int          drain_last = -1;   // last cycle of the post-CP0 stall window
    bit          waiting    = 1'b0; // interrupt tag in flight

    bit          m_accept;
    logic [31:0] m_tgt;
    bit          m_dcause;
    logic [3:0]  exp_flush;
    bit          exp_rv, exp_stall, exp_int;
    logic [31:0] exp_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.exception_valid = 1'b0;
        bus.eret_exist      = 1'b0;
        bus.mtc0_exist      = 1'b0;
        bus.jmp_valid       = 1'b0;
        bus.int_pending     = 1'b0;
        bus.stage_valid     = '0;
    endtask

    // Called just after the falling edge once inputs are set: compute what
    // the outputs must be this cycle and compare.
    task automatic eval();
        bit ev, in_redir, in_drain, idle;
        #1;
        ev = bus.exception_valid | bus.eret_exist | bus.jmp_valid | bus.mtc0_exist;
        if (bus.exception_valid) begin m_tgt = bus.exc_vector; m_dcause = 1'b0; end
        else if (bus.eret_exist) begin m_tgt = bus.epc;        m_dcause = 1'b1; end
        else if (bus.jmp_valid)  begin m_tgt = bus.jmp_pc;     m_dcause = 1'b0; end
        else                     begin m_tgt = bus.wb_pc + 32'd8; m_dcause = 1'b1; end

        in_redir = (redir_cyc == cyc);
        in_drain = !in_redir && (cyc <= drain_last);
        idle     = !in_redir && !in_drain && !waiting;

        m_accept  = resetn && (((idle || waiting) && ev) || (in_drain && bus.exception_valid));
        exp_int   = resetn && idle && !ev && bus.int_pending && bus.stage_valid[NS-1];
        exp_flush = (resetn && (in_redir || m_accept)) ? 4'hF : 4'h0;
        exp_rv    = in_redir;
        exp_rpc   = in_redir ? redir_pc_m : 32'h0;
        exp_stall = in_drain || waiting;

        chk("flush",          32'(bus.flush),          32'(exp_flush));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(exp_rv));
        chk("redirect_pc",    bus.redirect_pc,         exp_rpc);
        chk("stall_issue",    32'(bus.stall_issue),    32'(exp_stall));
        chk("int_take",       32'(bus.int_take),       32'(exp_int));
    endtask

    task automatic adv();
        @(posedge clk);
        if (!resetn) begin
            redir_cyc  = -1;
            drain_last = -1;
            waiting    = 1'b0;
        end else if (m_accept) begin
            redir_cyc  = cyc + 1;
            redir_pc_m = m_tgt;
            drain_last = m_dcause ? (cyc + 1 + D) : -1;
            waiting    = 1'b0;
        end else if (exp_int) begin
            waiting = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.jmp_pc     = '0;
        bus.exc_vector = EXC_ENTRY;
        bus.epc        = '0;
        bus.wb_pc      = '0;
        set_idle();

        // Reset held for two edges; check outputs after the first.
        @(negedge clk);
        eval();
        chk("reset_rpc", bus.redirect_pc, 32'h0);
        adv();
        resetn = 1'b1;
        eval(); adv();

        // Jump
        bus.jmp_valid = 1'b1; bus.jmp_pc = 32'h8000_0100;
        eval(); chk("jmp_flush_t", 32'(bus.flush), 32'hF); adv();
        set_idle();
        eval(); chk("jmp_rv_t1", 32'(bus.redirect_valid), 32'd1);
                chk("jmp_rpc_t1", bus.redirect_pc, 32'h8000_0100); adv();
        eval(); chk("jmp_stall_t2", 32'(bus.stall_issue), 32'd0); adv();

        // Exception beats jump
        bus.exception_valid = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_pc = 32'h8000_0200;
        eval(); adv();
        set_idle();
        eval(); chk("exc_rpc", bus.redirect_pc, 32'hBFC0_0380); adv();
        eval(); chk("exc_nodrain", 32'(bus.stall_issue), 32'd0); adv();

        // MTC0
        bus.mtc0_exist = 1'b1; bus.wb_pc = 32'h8000_0040;
        eval(); adv();
        set_idle();
        eval(); chk("mtc0_rpc", bus.redirect_pc, 32'h8000_0048); adv();
        eval(); chk("mtc0_stall_t2", 32'(bus.stall_issue), 32'd1); adv();
        eval(); chk("mtc0_stall_t3", 32'(bus.stall_issue), 32'd1); adv();
        eval(); chk("mtc0_stall_t4", 32'(bus.stall_issue), 32'd0); adv();

        // Interrupt with memory stage valid
        bus.int_pending = 1'b1; bus.stage_valid = 4'b1000;
        eval(); chk("int_take_t", 32'(bus.int_take), 32'd1); adv();
        eval(); chk("int_take_t1", 32'(bus.int_take), 32'd0);
                chk("int_wait_stall", 32'(bus.stall_issue), 32'd1); adv();
        bus.exception_valid = 1'b1;
        eval(); chk("int_exc_flush", 32'(bus.flush), 32'hF); adv();
        bus.exception_valid = 1'b0;
        eval(); chk("int_exc_rpc", bus.redirect_pc, 32'hBFC0_0380);
                chk("int_no_second", 32'(bus.int_take), 32'd0); adv();
        set_idle();
        eval(); adv();

        // Interrupt with empty memory stage
        bus.int_pending = 1'b1; bus.stage_valid = 4'b0111;
        eval(); chk("int_empty_a", 32'(bus.int_take), 32'd0); adv();
        eval(); chk("int_empty_b", 32'(bus.int_take), 32'd0); adv();
        bus.stage_valid = 4'b1111;
        eval(); chk("int_mem_valid", 32'(bus.int_take), 32'd1); adv();
        set_idle(); bus.exception_valid = 1'b1;
        eval(); adv();
        set_idle();
        eval(); adv();
        eval(); adv();

        // ERET, then exception preempting the drain
        bus.eret_exist = 1'b1; bus.epc = 32'h8000_1000;
        eval(); adv();
        set_idle();
        eval(); chk("eret_rpc", bus.redirect_pc, 32'h8000_1000); adv();
        bus.exception_valid = 1'b1;
        eval(); chk("drain_exc_flush", 32'(bus.flush), 32'hF);
                chk("drain_exc_stall", 32'(bus.stall_issue), 32'd1); adv();
        set_idle();
        eval(); chk("drain_exc_rpc", bus.redirect_pc, 32'hBFC0_0380); adv();
        eval(); chk("drain_exc_nostall", 32'(bus.stall_issue), 32'd0); adv();

        // Reset in the middle of a drain
        bus.eret_exist = 1'b1;
        eval(); adv();
        set_idle();
        eval(); adv();
        resetn = 1'b0;
        eval(); adv();
        resetn = 1'b1;
        eval(); chk("rst_drain_stall", 32'(bus.stall_issue), 32'd0);
                chk("rst_drain_rv", 32'(bus.redirect_valid), 32'd0); adv();

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            resetn              = ($urandom_range(0, 199) != 0);
            bus.exception_valid = ($urandom_range(0, 11) == 0);
            bus.eret_exist      = ($urandom_range(0, 9) == 0);
            bus.jmp_valid       = ($urandom_range(0, 7) == 0);
            bus.mtc0_exist      = ($urandom_range(0, 9) == 0);
            bus.int_pending     = ($urandom_range(0, 2) == 0);
            bus.stage_valid     = 4'($urandom_range(0, 15));
            bus.jmp_pc          = $urandom;
            bus.epc             = $urandom;
            bus.wb_pc           = $urandom;
            bus.exc_vector      = ($urandom_range(0, 1) == 0) ? EXC_ENTRY : $urandom;
            eval();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_redirect_ctrl.md
Name: wb_redirect_ctrl

Overview:
Central redirect/flush sequencer for the dual-issue writeback stage. It consumes the writeback summary signals (exception, ERET, MTC0, branch/jump forward) and the CP0 interrupt-pending state. It prioritises these events, flushes the younger pipeline stages, issues a registered PC redirect to fetch, and serialises issue after CP0 writes. It also injects asynchronous interrupts by tagging the oldest in-flight instruction.

Parameters:
- NUM_STAGES, 4, number of flushable stages; bit 0 = fetch … bit NUM_STAGES-1 = memory.
- DRAIN_CYCLES, 2, cycles issue is held after a redirect caused by MTC0 or ERET, so CP0 state settles.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- exception_valid  in  1  either writeback lane carries an exception.
- eret_exist  in  1  either writeback lane is ERET.
- mtc0_exist  in  1  either writeback lane is MTC0.
- jmp_valid  in  1  writeback jump forward is valid.
- jmp_pc  in  PC_W  jump target.
- exc_vector  in  PC_W  exception entry PC (already computed from CP0).
- epc  in  PC_W  CP0.EPC value, post-writeback.
- wb_pc  in  PC_W  PC of writeback lane 2 (resume point after MTC0).
- int_pending  in  1  (Cause.IP & Status.IM) != 0 && Status.IE && !Status.EXL.
- stage_valid  in  NUM_STAGES  valid bit per stage.
- flush  out  NUM_STAGES  kill the contents of each stage.
- stall_issue  out  1  hold fetch/decode.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  PC_W  new fetch PC.
- int_take  out  1  tag the memory-stage instruction with an interrupt exception.

Behaviour:
- Reset: state=IDLE, counter=0. All outputs 0, redirect_pc=0.
- Event priority, evaluated combinationally in cycle t: exception > ERET > jump > MTC0.
- Target PC by event:
  - exception → exc_vector
  - ERET → epc
  - jump → jmp_pc
  - MTC0 → wb_pc+8 (resume after the pair)
- States: IDLE, REDIRECT, DRAIN, INT_WAIT.
- IDLE with an event at t:
  - flush = all ones, combinationally in cycle t. This stops the younger memory contents entering writeback.
  - The target is latched. State → REDIRECT.
- REDIRECT (t+1):
  - redirect_valid=1, redirect_pc=latched target, flush=all ones.
  - Writeback events in this cycle come from squashed instructions and are ignored.
  - Next state: DRAIN if the cause was MTC0 or ERET and DRAIN_CYCLES>0, loading counter=DRAIN_CYCLES. Otherwise IDLE.
- DRAIN:
  - stall_issue=1 and counter decrements each cycle.
  - Reaching 1 → IDLE on the next edge.
  - An exception_valid during DRAIN preempts: same handling as IDLE with an exception event.
- Interrupt injection:
  - Condition: IDLE, int_pending=1, no event this cycle, and stage_valid[NUM_STAGES-1]=1.
  - Action: int_take pulses one cycle, state → INT_WAIT.
- INT_WAIT:
  - stall_issue=1; int_take stays 0.
  - exception_valid → normal exception path, to REDIRECT.
  - A jump/ERET/MTC0 arriving first (an older instruction) is handled normally, and the interrupt is re-evaluated afterwards.
- int_take is never asserted when the memory stage is empty, or in any state other than IDLE.
- Counter width: $clog2(DRAIN_CYCLES+1). No wrap; it saturates at 0.
- A resetn deassertion mid-sequence returns to IDLE on the next edge and drops all strobes.
- Latency: flush in cycle 0, redirect in cycle 1.

Decomposition:
- Shared package (mycpu.svh):
  - redirect_cause_e {RC_NONE, RC_EXC, RC_ERET, RC_JMP, RC_MTC0}
  - wbctl_state_e
  - localparam EXC_ENTRY default 32'hBFC0_0380
- Sub-module: wb_event_prio. Combinational priority encoder producing cause + target; kept separately testable.
- Top holds the FSM, target register and drain counter.

Test Plan:
- Jump: jmp_valid=1, jmp_pc=0x8000_0100 at t → flush=4'hF at t; redirect_valid=1, redirect_pc=0x8000_0100 at t+1; IDLE at t+2, no stall.
- Exception+jump same cycle: exc_vector=0xBFC0_0380, jmp_pc=0x8000_0200 → redirect_pc=0xBFC0_0380; no drain.
- MTC0 with wb_pc=0x8000_0040: redirect_pc=0x8000_0048 at t+1; stall_issue=1 for exactly t+2..t+3; clear at t+4.
- Interrupt: int_pending=1, stage_valid=4'b1000 → int_take=1 for one cycle. exception_valid two cycles later → redirect to 0xBFC0_0380; no second int_take.
- Interrupt with stage_valid=4'b0111 → int_take stays 0 until the memory stage becomes valid.
- ERET then exception_valid during DRAIN → new redirect to exc_vector; resetn=0 mid-DRAIN → all outputs 0 next cycle.
